// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage <-> multiply/divide unit handshake and HI/LO result bus.
interface hilo_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             op_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, op_signed, src_a, src_b,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, op_signed, src_a, src_b,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULT/DIV with HI/LO registers and MTHI/MTLO writes.
// Optional signed MULT/DIV enabled by defining SIGNED_MD_EN.
module hilo_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       reset,
  hilo_mdu_if.slave bus
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 bz_q, bz_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;

  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 last;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_tr;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;

`ifdef SIGNED_MD_EN
  assign sa    = bus.op_signed & bus.src_a[WIDTH-1];
  assign sb    = bus.op_signed & bus.src_b[WIDTH-1];
  assign mag_a = sa ? -bus.src_a : bus.src_a;
  assign mag_b = sb ? -bus.src_b : bus.src_b;
`else
  assign sa    = 1'b0;
  assign sb    = 1'b0;
  assign mag_a = bus.src_a;
  assign mag_b = bus.src_b;
`endif

  assign last = (cnt_q == CNT_W'(WIDTH-1));

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_nxt = acc_q[0]
                 ? {mul_sum, acc_q[WIDTH-1:1]}
                 : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring step: remainder in the high half, quotient shifts into the low.
  assign div_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_tr  = div_sh - {1'b0, opnd_q};
  assign div_nxt = div_tr[WIDTH]
                 ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                 : {div_tr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    prod = mul_nxt;
    quo  = div_nxt[WIDTH-1:0];
    rem  = div_nxt[2*WIDTH-1:WIDTH];
`ifdef SIGNED_MD_EN
    if (qneg_q) prod = -prod;
    if (qneg_q) quo  = -quo;
    if (rneg_q) rem  = -rem;
`endif
    if (bz_q) quo = {WIDTH{1'b1}};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    bz_d    = bz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            (bus.op == OP_MTHI): hi_d = bus.src_a;
            (bus.op == OP_MTLO): lo_d = bus.src_a;
            (bus.op == OP_MULT): begin
              state_d = S_MUL;
              cnt_d   = '0;
              opnd_d  = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              qneg_d  = sa ^ sb;
              rneg_d  = 1'b0;
              bz_d    = 1'b0;
            end
            (bus.op == OP_DIV): begin
              state_d = S_DIV;
              cnt_d   = '0;
              opnd_d  = mag_b;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              qneg_d  = sa ^ sb;
              rneg_d  = sa;
              bz_d    = (bus.src_b == '0);
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = rem;
          lo_d    = quo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      bz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      bz_q    <= bz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed vectors with a done-driven scoreboard for hilo_mdu.
// Signed vectors are exercised when SIGNED_MD_EN is defined.
module tb_hilo_mdu;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   busy_cnt;
  exp_t sbq[$];

  hilo_mdu_if #(.WIDTH(32)) bus ();

  hilo_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no result");
        end else begin
          e = sbq.pop_front();
          check({e.nm, "_hi"}, bus.hi_out, e.hi);
          check({e.nm, "_lo"}, bus.lo_out, e.lo);
          check({e.nm, "_lat"}, busy_cnt, 32);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sg,
                       input bit push, input logic [31:0] ehi,
                       input logic [31:0] elo, input string nm);
    exp_t e;
    bus.op        = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.op_signed = sg;
    bus.start     = 1'b1;
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      e.nm = nm;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    if (k == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 expected idle within 100", nm);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    n_chk         = 0;
    n_fail        = 0;
    busy_cnt      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.op_signed = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;

    @(negedge clk);
    check("rst_hi", bus.hi_out, 32'h0);
    check("rst_lo", bus.lo_out, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(OP_MULT, 32'd7, 32'd6, 1'b0, 1, 32'h0, 32'h2A, "mul7x6");
    check("mul_busy", {31'b0, bus.busy}, 32'h1);
    wait_idle("mul7x6");

    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1,
          32'hFFFFFFFE, 32'h1, "mulmax");
    wait_idle("mulmax");

    issue(OP_DIV, 32'd100, 32'd7, 1'b0, 1, 32'd2, 32'd14, "div100_7");
    wait_idle("div100_7");

    issue(OP_DIV, 32'd5, 32'd0, 1'b0, 1, 32'd5, 32'hFFFFFFFF, "div5_0");
    wait_idle("div5_0");

    // Start accepted in the same cycle that done is high.
    issue(OP_MULT, 32'd3, 32'd5, 1'b0, 1, 32'h0, 32'd15, "mul3x5");
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (k == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL b2b_timeout: got done=0 expected done within 100");
    end
    issue(OP_DIV, 32'd50, 32'd8, 1'b0, 1, 32'd2, 32'd6, "div_b2b");
    check("b2b_busy", {31'b0, bus.busy}, 32'h1);
    wait_idle("div_b2b");

    issue(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 0, 32'h0, 32'h0, "mthi");
    check("mthi_hi", bus.hi_out, 32'hDEADBEEF);
    check("mthi_lo", bus.lo_out, 32'd6);
    check("mthi_busy", {31'b0, bus.busy}, 32'h0);
    check("mthi_done", {31'b0, bus.done}, 32'h0);
    issue(OP_MTLO, 32'h12345678, 32'h0, 1'b0, 0, 32'h0, 32'h0, "mtlo");
    check("mtlo_lo", bus.lo_out, 32'h12345678);
    check("mtlo_hi", bus.hi_out, 32'hDEADBEEF);
    check("mtlo_busy", {31'b0, bus.busy}, 32'h0);

    // MTHI during busy is dropped; HI/LO hold old values until completion.
    issue(OP_DIV, 32'd1000, 32'd10, 1'b0, 1, 32'd0, 32'd100, "div_ign");
    repeat (9) @(posedge clk);
    #1;
    bus.op    = OP_MTHI;
    bus.src_a = 32'h1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("ign_hi", bus.hi_out, 32'hDEADBEEF);
    check("ign_lo", bus.lo_out, 32'h12345678);
    check("ign_busy", {31'b0, bus.busy}, 32'h1);
    wait_idle("div_ign");

    // Reset mid-operation aborts with no done pulse.
    issue(OP_DIV, 32'd77, 32'd3, 1'b0, 0, 32'h0, 32'h0, "div_abort");
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_hi", bus.hi_out, 32'h0);
    check("abort_lo", bus.lo_out, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_done", {31'b0, bus.done}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", {31'b0, bus.busy}, 32'h0);

`ifdef SIGNED_MD_EN
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1,
          32'hFFFFFFFF, 32'hFFFFFFFD, "sdiv");
    wait_idle("sdiv");
    issue(OP_MULT, 32'hFFFFFFFD, 32'd4, 1'b1, 1,
          32'hFFFFFFFF, 32'hFFFFFFF4, "smul");
    wait_idle("smul");
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1,
          32'h0, 32'h80000000, "sovf");
    wait_idle("sovf");
    issue(OP_DIV, 32'hFFFFFFFB, 32'h0, 1'b1, 1,
          32'hFFFFFFFB, 32'hFFFFFFFF, "sdiv0");
    wait_idle("sdiv0");
`else
    issue(OP_MULT, 32'hFFFFFFFD, 32'd4, 1'b1, 1,
          32'h3, 32'hFFFFFFF4, "umul_sg");
    wait_idle("umul_sg");
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1,
          32'h1, 32'h7FFFFFFC, "udiv_sg");
    wait_idle("udiv_sg");
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
